// File: rtl/timer_count_core.sv
// Down-counting timer engine with prescaler, one-shot/periodic modes and sticky expiry irq.
// Optional capture of the live count on a cap_in rising edge when TIMER_CAPTURE_EN is defined.
module timer_count_core #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mod_en,
    input  logic               start,
    input  logic               stop,
    input  logic               periodic,
    input  logic [CNT_W-1:0]   load_val,
    input  logic [PRESC_W-1:0] presc_val,
    input  logic               irq_clr,
`ifdef TIMER_CAPTURE_EN
    input  logic               cap_in,
    output logic [CNT_W-1:0]   cap_val,
    output logic               cap_valid,
`endif
    output logic [CNT_W-1:0]   count,
    output logic               running,
    output logic               tick,
    output logic               irq
);

    // state | meaning
    // IDLE  | not counting, count holds
    // RUN   | counting down on each prescaled tick
    // DONE  | one-shot expired, count holds 0
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               running_q, running_d;
    logic               irq_q, irq_d;
    logic               expire;

    assign tick    = (state_q == RUN) && (presc_cnt_q == '0);
    assign count   = count_q;
    assign running = running_q;
    assign irq     = irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            presc_cnt_q <= '0;
            running_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            presc_cnt_q <= presc_cnt_d;
            running_q   <= running_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        presc_cnt_d = presc_cnt_q;
        expire      = 1'b0;

        if (!mod_en) begin
            state_d     = IDLE;
            presc_cnt_d = '0;
        end else if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d     = RUN;
            count_d     = load_val;
            presc_cnt_d = presc_val;
        end else if (state_q == RUN) begin
            if (tick) begin
                presc_cnt_d = presc_val;
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    expire = 1'b1;
                    if (periodic) begin
                        count_d = load_val;
                    end else begin
                        state_d = DONE;
                    end
                end
            end else begin
                presc_cnt_d = presc_cnt_q - 1'b1;
            end
        end

        running_d = (state_d == RUN);

        // Expiry set beats a same-cycle clear so an event is never lost.
        irq_d = irq_q;
        if (irq_clr) irq_d = 1'b0;
        if (expire)  irq_d = 1'b1;
    end

`ifdef TIMER_CAPTURE_EN
    logic             cap_in_q;
    logic [CNT_W-1:0] cap_val_q, cap_val_d;
    logic             cap_valid_q, cap_valid_d;
    logic             cap_rise;

    assign cap_rise  = cap_in && !cap_in_q;
    assign cap_val   = cap_val_q;
    assign cap_valid = cap_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_in_q    <= 1'b0;
            cap_val_q   <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_in_q    <= cap_in;
            cap_val_q   <= cap_val_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    always_comb begin
        cap_val_d   = cap_val_q;
        cap_valid_d = cap_valid_q;
        if (irq_clr) cap_valid_d = 1'b0;
        if (cap_rise) begin
            cap_val_d   = count_q;
            cap_valid_d = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_timer_count_core.sv
// Directed self-checking bench for timer_count_core; capture checks run when TIMER_CAPTURE_EN is defined.
module tb_timer_count_core;

    localparam int CNT_W   = 32;
    localparam int PRESC_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               mod_en;
    logic               start;
    logic               stop;
    logic               periodic;
    logic [CNT_W-1:0]   load_val;
    logic [PRESC_W-1:0] presc_val;
    logic               irq_clr;
    logic [CNT_W-1:0]   count;
    logic               running;
    logic               tick;
    logic               irq;
`ifdef TIMER_CAPTURE_EN
    logic               cap_in;
    logic [CNT_W-1:0]   cap_val;
    logic               cap_valid;
`endif

    int n_cmp = 0;
    int n_err = 0;

    timer_count_core #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mod_en    (mod_en),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .load_val  (load_val),
        .presc_val (presc_val),
        .irq_clr   (irq_clr),
`ifdef TIMER_CAPTURE_EN
        .cap_in    (cap_in),
        .cap_val   (cap_val),
        .cap_valid (cap_valid),
`endif
        .count     (count),
        .running   (running),
        .tick      (tick),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; mod_en = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0;
        load_val = '0; presc_val = '0; irq_clr = 1'b0;
`ifdef TIMER_CAPTURE_EN
        cap_in = 1'b0;
`endif
        repeat (2) cyc();
        chk("rst_count", count, 0);
        chk("rst_running", running, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tick", tick, 0);
        rst = 1'b0;
        cyc();

        // one-shot, load 5, no prescale
        mod_en = 1'b1; presc_val = 8'd0; load_val = 32'd5; periodic = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        chk("os_count_n1", count, 5);
        chk("os_running_n1", running, 1);
        chk("os_tick_n1", tick, 1);
        for (int i = 4; i >= 0; i--) begin
            cyc();
            chk($sformatf("os_count_%0d", i), count, i);
        end
        chk("os_irq_n6", irq, 0);
        cyc();
        chk("os_irq_n7", irq, 1);
        chk("os_running_done", running, 0);
        repeat (3) cyc();
        chk("os_count_hold0", count, 0);
        chk("os_tick_done", tick, 0);
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        chk("os_irq_clr", irq, 0);

        // periodic, prescale 3, load 2
        presc_val = 8'd3; load_val = 32'd2; periodic = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        chk("per_count_n1", count, 2);
        chk("per_tick_n1", tick, 0);
        repeat (3) cyc();
        chk("per_tick_n4", tick, 1);
        chk("per_count_n4", count, 2);
        cyc();
        chk("per_count_n5", count, 1);
        repeat (7) cyc();
        chk("per_count_n12", count, 0);
        chk("per_tick_n12", tick, 1);
        chk("per_irq_n12", irq, 0);
        cyc();
        chk("per_irq_n13", irq, 1);
        chk("per_reload_n13", count, 2);
        chk("per_running", running, 1);
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        chk("per_irq_clr", irq, 0);
        repeat (10) cyc();
        chk("per_irq_n24", irq, 0);
        chk("per_tick_n24", tick, 1);
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        chk("per_set_wins", irq, 1);
        chk("per_reload_n25", count, 2);

        // stop at 7, hold, restart with 9
        irq_clr = 1'b1; presc_val = 8'd0; load_val = 32'd10; periodic = 1'b0;
        start = 1'b1; cyc(); start = 1'b0; irq_clr = 1'b0;
        chk("ss_count10", count, 10);
        repeat (3) cyc();
        chk("ss_count7", count, 7);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("ss_stop_count", count, 7);
        chk("ss_stop_running", running, 0);
        repeat (10) cyc();
        chk("ss_hold_count", count, 7);
        chk("ss_hold_tick", tick, 0);
        load_val = 32'd9;
        start = 1'b1; cyc(); start = 1'b0;
        chk("ss_restart_count", count, 9);
        chk("ss_restart_running", running, 1);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("col_ss_running", running, 0);
        chk("col_ss_count", count, 9);

        // mod_en drop mid-run
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("men_count8", count, 8);
        mod_en = 1'b0; cyc();
        chk("men_running", running, 0);
        chk("men_count_frozen", count, 8);
        start = 1'b1; cyc(); start = 1'b0;
        chk("men_start_ignored", running, 0);
        chk("men_count_still", count, 8);
        mod_en = 1'b1;

        // load 0 expires on first tick
        irq_clr = 1'b1; load_val = 32'd0;
        start = 1'b1; cyc(); start = 1'b0; irq_clr = 1'b0;
        chk("l0_count", count, 0);
        chk("l0_irq_pre", irq, 0);
        chk("l0_tick", tick, 1);
        cyc();
        chk("l0_irq", irq, 1);
        chk("l0_done", running, 0);

        // max prescale: one tick per 256 cycles
        presc_val = 8'hFF; load_val = 32'd1;
        start = 1'b1; cyc(); start = 1'b0;
        chk("pm_tick_n1", tick, 0);
        repeat (254) cyc();
        chk("pm_tick_n255", tick, 0);
        cyc();
        chk("pm_tick_n256", tick, 1);
        chk("pm_count_n256", count, 1);
        cyc();
        chk("pm_count_n257", count, 0);
        chk("pm_tick_n257", tick, 0);

        // reset mid-count
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        presc_val = 8'd0; load_val = 32'd50;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (3) cyc();
        chk("mr_count47", count, 47);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mr_count", count, 0);
        chk("mr_running", running, 0);
        chk("mr_tick", tick, 0);

`ifdef TIMER_CAPTURE_EN
        chk("cap_rst_valid", cap_valid, 0);
        load_val = 32'd25;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (5) cyc();
        chk("cap_count20", count, 20);
        cap_in = 1'b1; cyc();
        chk("cap_val", cap_val, 20);
        chk("cap_valid", cap_valid, 1);
        cyc();
        chk("cap_level_no_recapture", cap_val, 20);
        cap_in = 1'b0;
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        chk("cap_clr", cap_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_count_core.md
Name: timer_count_core

Overview:
Down-counting timer engine. Sits directly downstream of count_registers and consumes its decoded control fields: enable, start/stop strobes, load value, prescaler and mode. Produces the live count, a running flag and a sticky expiry interrupt, which count_registers reads back through rdata. Single clock domain; no bus logic inside.

Parameters:
CNT_W, 32, counter and load-value width
PRESC_W, 8, prescaler width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
mod_en  input  1  module enable from register block
start  input  1  one-cycle strobe: load and run
stop  input  1  one-cycle strobe: halt counting
periodic  input  1  1 = auto-reload on expiry; 0 = one-shot
load_val  input  CNT_W  reload value
presc_val  input  PRESC_W  prescaler divide-minus-one
irq_clr  input  1  one-cycle strobe: clear irq
count  output  CNT_W  current counter value
running  output  1  high in RUN state
tick  output  1  prescaled count enable (combinational, RUN only)
irq  output  1  sticky expiry flag

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Sampled on rising clk.
- Reset: state=IDLE, count=0, presc_cnt=0, running=0, irq=0, tick=0.
- States:
  - IDLE: not counting.
  - RUN: counting.
  - DONE: one-shot expired, count holds 0.
- tick = (state==RUN) && (presc_cnt==0).
- In RUN:
  - tick=0 → presc_cnt decrements.
  - tick=1 → presc_cnt reloads presc_val.
- On tick with count!=0 → count <= count-1.
- On tick with count==0 → expiry:
  - irq <= 1.
  - periodic=1: count <= load_val, stay RUN.
  - periodic=0: go to DONE, count stays 0.
- start, in any state with mod_en=1 → count <= load_val, presc_cnt <= presc_val, go to RUN. A start while in RUN restarts.
- stop → go to IDLE; count holds its value. A later start reloads the count.
- start and stop in the same cycle → stop wins.
- mod_en=0 → forced to IDLE at the next edge; start is ignored; count and irq hold; presc_cnt <= 0.
- irq_clr → irq <= 0. If expiry and irq_clr occur in the same cycle, set wins.
- running = (state==RUN), registered.
- Latency, presc_val=0, start at cycle N:
  - running=1 and count=L at N+1.
  - count=0 at N+1+L.
  - irq=1 at N+2+L.
  - Periodic expiry interval = (L+1)*(presc_val+1) cycles.
- Boundaries:
  - load_val=0 → expires on the first tick.
  - presc_val=max → one tick per 2^PRESC_W cycles.
  - Counter never wraps below 0.
  - load_val and presc_val changes take effect only at the next reload.
- rst mid-count → all state returns to reset values on the next edge.

Optional Feature:
TIMER_CAPTURE_EN.
- Defined: adds ports
  - cap_in  input  1  asynchronous-free event input, already synchronised
  - cap_val  output  CNT_W
  - cap_valid  output  1
- On a cap_in rising edge (registered previous value), cap_val <= count and cap_valid <= 1.
- cap_valid clears on irq_clr. Capture takes priority over clear in the same cycle.
- cap_val and cap_valid reset to 0.
- Not defined: ports absent, no capture logic; behaviour otherwise identical.

Test Plan:
- Reset: rst high for 2 cycles → count=0, running=0, irq=0, tick=0.
- One-shot: presc_val=0, load_val=5, periodic=0, pulse start at N → count 5,4,3,2,1,0 at N+1..N+6; irq=1 at N+7; DONE; count holds 0.
- Periodic with prescaler: presc_val=3, load_val=2 → tick every 4 cycles; irq set every 12 cycles after the first; irq_clr then re-sets on the next expiry.
- Stop/restart: stop at count=7 → count holds 7 for 10 cycles, running=0; start with load_val=9 → count=9 next cycle.
- Collisions:
  - start+stop same cycle → IDLE.
  - expiry+irq_clr same cycle → irq=1.
  - mod_en=0 mid-run → IDLE, count frozen, start ignored.
- TIMER_CAPTURE_EN: cap_in rises while count=20 → cap_val=20, cap_valid=1; irq_clr → cap_valid=0.
